tnn_clf_scheduler: RTL and testbench
====================================

// Module: tnn_clf_scheduler
// PURPOSE
// - Shares one combinational 5x2-bit TNN classifier core among NUM_REQ requesters.
// - The core is external: this block drives clf_feat and samples clf_class.
//   Any evolved or approximate core variant can be swapped in with no change here.
// - Round-robin arbitration feeds a 2-stage registered pipeline
//   (feature stage S1 -> result stage S2) with valid/ready backpressure.
// - Sits between per-channel sample producers and the downstream decision or vote logic.
// PARAMETERS
// NUM_REQ   4   number of requesters (2..16)
// FEAT_W    2   bits per feature
// NUM_FEAT  5   features per vector; VEC_W = FEAT_W*NUM_FEAT = 10
// CNT_W     16  statistics counter width (used only with TNN_STATS_EN)
// PORTS
// clk        in   1               single clock, rising edge
// rst_n      in   1               synchronous reset, active-low
// en         in   1               1 = grants allowed; 0 = no new grants, pipeline drains
// req_valid  in   NUM_REQ         per-requester vector valid
// req_ready  out  NUM_REQ         one-hot accept; combinational from req_valid, S1/S2 state, pointer
// req_feat   in   NUM_REQ*VEC_W   packed vectors; requester i at [i*VEC_W +: VEC_W]
//                                 feature k of a vector at [k*FEAT_W +: FEAT_W]
// clf_feat   out  VEC_W           registered S1 vector driven to the core
// clf_class  in   1               core decision for clf_feat
// res_valid  out  1               S2 holds a result
// res_ready  in   1               downstream accepts the result
// res_class  out  1               registered class bit
// res_id     out  $clog2(NUM_REQ) requester that issued the vector
// stat_pos   out  NUM_REQ*CNT_W   [TNN_STATS_EN only] class-1 count per requester
// stat_tot   out  NUM_REQ*CNT_W   [TNN_STATS_EN only] result count per requester
// stat_clr   in   1               [TNN_STATS_EN only] synchronous clear of all counters
// BEHAVIOUR
// - Reset: all of the following are 0 = S1/S2 valid bits, rr pointer, clf_feat,
//   res_class, res_id, req_ready, res_valid, and all counters.
// - Reset mid-operation discards in-flight vectors. No result is emitted for them.
// - s1_adv = s1_v & (~s2_v | res_ready).
// - grant_ok = en & (~s1_v | s1_adv).
// - Arbitration: search req_valid starting at the pointer, wrap modulo NUM_REQ.
//   The first valid requester i gets req_ready[i] = grant_ok. All other ready bits are 0.
// - Accept when req_valid[i] & req_ready[i]:
//   - S1 loads the vector and id i.
//   - s1_v is set.
//   - pointer <= (i+1) mod NUM_REQ.
// - No accept: pointer holds; s1_v clears if s1_adv.
// - clf_feat holds its last value when S1 is empty. It never glitches to X.
// - S2 capture on s1_adv: res_class <= clf_class, res_id <= S1 id, s2_v <= 1.
// - s2_v clears on res_valid & res_ready when no simultaneous s1_adv.
// - Simultaneous S2 pop and S1 advance: S2 reloads in the same cycle. No bubble.
// - Latency: accept at edge T -> res_valid high after edge T+2.
//   Throughput is 1 vector/cycle when res_ready is held high.
// - Stall: res_ready=0 with S2 full holds S2, S1 and clf_feat stable.
//   A grant is possible only if S1 is empty.
// - Result outputs stay stable while res_valid & ~res_ready.
// - en=0 affects only new grants. In-flight vectors complete normally.
// - Single requester: it is granted every free cycle.
// CONFIGURATION
// - `define TNN_STATS_EN: adds the stat_pos, stat_tot and stat_clr ports and the counters.
//   - Counters increment on each res handshake for res_id. stat_pos increments only if res_class=1.
//   - Counters saturate at 2^CNT_W-1.
//   - stat_clr has priority over a same-cycle increment.
// - Without the macro: the ports and logic are absent. Core behaviour is identical.
// STRUCTURE
// - Package tnn_sched_pkg holds:
//   - FEAT_W and NUM_FEAT defaults, and the VEC_W localparam.
//   - typedef feat_vec_t = logic [VEC_W-1:0].
//   - function clog2_safe for id width (returns >=1).
// - Sub-module tnn_rr_arbiter(NUM_REQ) holds the rotating-priority search and pointer:
//   - inputs: req, advance
//   - outputs: one-hot grant, grant index
// - Top level holds the S1/S2 pipeline, the result interface and the optional stats.
// TESTING
// 1. Reset/idle: rst_n=0 for 3 cycles, then all req_valid=0.
//    -> res_valid=0 and req_ready=0 throughout; clf_feat=10'h000.
// 2. Latency: req 2 issues 10'h155 at edge T, res_ready=1, model returns 1.
//    -> clf_feat=10'h155 after T+1; res_valid, res_class=1, res_id=2 after T+2.
// 3. Fairness: all 4 requesters valid continuously, res_ready=1.
//    -> grant order 0,1,2,3,0,1,... ; one result per cycle; no starvation.
// 4. Backpressure: res_ready=0 for 5 cycles with traffic.
//    -> S2 and clf_feat frozen; at most 2 vectors in flight.
//    -> On release, results appear in order with no loss or duplication.
// 5. Mid-operation reset: rst_n=0 for 1 cycle with S1 and S2 full.
//    -> next cycle res_valid=0 and pointer=0; the next grant goes to the lowest valid id.
// 6. TNN_STATS_EN: 300 results to id 1, all class 1, CNT_W=8.
//    -> stat_pos[1] and stat_tot[1] saturate at 255; stat_clr zeroes them the next cycle.

Source files
------------

// File: rtl/tnn_sched_pkg.sv
// Shared parameters, vector type and id-width helper
// for the TNN classifier scheduler.
package tnn_sched_pkg;

  localparam int FEAT_W_DEF   = 2;
  localparam int NUM_FEAT_DEF = 5;
  localparam int VEC_W        = FEAT_W_DEF * NUM_FEAT_DEF;

  typedef logic [VEC_W-1:0] feat_vec_t;

  // Id width that never collapses to zero bits.
  function automatic int clog2_safe(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/tnn_rr_arbiter.sv
// Rotating-priority arbiter: the search starts at the pointer.
// Ports: req_i, advance_i in; grant_o (one-hot), idx_o out.
module tnn_rr_arbiter
  import tnn_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = clog2_safe(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW:0]   sum;
  logic [IDW-1:0] j;
  logic           found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    sum     = '0;
    j       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ))
        sum = sum - (IDW+1)'(NUM_REQ);
      j = sum[IDW-1:0];
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      if (int'(idx_o) == NUM_REQ - 1)
        ptr_d = '0;
      else
        ptr_d = idx_o + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/tnn_clf_scheduler.sv
// Shares one external TNN classifier core among NUM_REQ
// requesters through a 2-stage valid/ready pipeline.
// Ports: req_valid/req_ready/req_feat in, clf_feat/clf_class
// core link, res_valid/res_ready/res_class/res_id out.
// Optional TNN_STATS_EN adds stat_pos, stat_tot, stat_clr.
module tnn_clf_scheduler
  import tnn_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int FEAT_W   = FEAT_W_DEF,
  parameter int NUM_FEAT = NUM_FEAT_DEF,
  parameter int CNT_W    = 16,
  parameter int VW       = FEAT_W * NUM_FEAT,
  parameter int IDW      = clog2_safe(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*VW-1:0] req_feat,
  output logic [VW-1:0]         clf_feat,
  input  logic                  clf_class,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_class,
`ifdef TNN_STATS_EN
  output logic [NUM_REQ*CNT_W-1:0] stat_pos,
  output logic [NUM_REQ*CNT_W-1:0] stat_tot,
  input  logic                     stat_clr,
`endif
  output logic [IDW-1:0]        res_id
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || CNT_W < 1) begin : g_chk
    $error("tnn_clf_scheduler: bad parameter");
  end

  logic           s1_v_q, s1_v_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic [VW-1:0]  feat_q, feat_d;
  logic           s2_v_q, s2_v_d;
  logic           cls_q, cls_d;
  logic [IDW-1:0] id_q, id_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gidx;
  logic [VW-1:0]      sel_feat;
  logic               s1_adv;
  logic               grant_ok;
  logic               accept;

  assign s1_adv = s1_v_q & (~s2_v_q | res_ready);
  // Reset gating keeps req_ready low while rst_n is held.
  assign grant_ok = rst_n & en & (~s1_v_q | s1_adv);
  assign req_ready = gnt & {NUM_REQ{grant_ok}};
  assign accept = grant_ok & (|gnt);

  tnn_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .advance_i (accept),
    .grant_o   (gnt),
    .idx_o     (gidx)
  );

  always_comb begin
    sel_feat = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) sel_feat = req_feat[i*VW +: VW];
  end

  always_comb begin
    s1_v_d  = s1_v_q;
    s1_id_d = s1_id_q;
    feat_d  = feat_q;
    if (accept) begin
      s1_v_d  = 1'b1;
      s1_id_d = gidx;
      feat_d  = sel_feat;
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end
  end

  // A pop and an advance in one cycle reload S2 directly.
  always_comb begin
    s2_v_d = s2_v_q;
    cls_d  = cls_q;
    id_d   = id_q;
    if (s1_adv) begin
      s2_v_d = 1'b1;
      cls_d  = clf_class;
      id_d   = s1_id_q;
    end else if (res_ready) begin
      s2_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q  <= 1'b0;
      s1_id_q <= '0;
      feat_q  <= '0;
      s2_v_q  <= 1'b0;
      cls_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      s1_id_q <= s1_id_d;
      feat_q  <= feat_d;
      s2_v_q  <= s2_v_d;
      cls_q   <= cls_d;
      id_q    <= id_d;
    end
  end

  assign clf_feat  = feat_q;
  assign res_valid = s2_v_q;
  assign res_class = cls_q;
  assign res_id    = id_q;

`ifdef TNN_STATS_EN
  logic hs;
  assign hs = s2_v_q & res_ready;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] tot_q, tot_d;
    logic             hit;

    assign hit = hs && (int'(id_q) == g);

    always_comb begin
      pos_d = pos_q;
      tot_d = tot_q;
      if (stat_clr) begin
        pos_d = '0;
        tot_d = '0;
      end else if (hit) begin
        if (tot_q != '1) tot_d = tot_q + CNT_W'(1);
        if (cls_q && pos_q != '1) pos_d = pos_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pos_q <= '0;
        tot_q <= '0;
      end else begin
        pos_q <= pos_d;
        tot_q <= tot_d;
      end
    end

    assign stat_pos[g*CNT_W +: CNT_W] = pos_q;
    assign stat_tot[g*CNT_W +: CNT_W] = tot_q;
  end
`endif

endmodule

// File: tb/tb_tnn_clf_scheduler.sv
// Randomized bench with a transaction-level model of the
// scheduler plus literal checks of latency, order and reset.
module tb_tnn_clf_scheduler;
  localparam int N  = 4;
  localparam int VW = 10;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*VW-1:0] req_feat;
  logic [VW-1:0] clf_feat;
  logic          clf_class;
  logic          res_valid;
  logic          res_ready;
  logic          res_class;
  logic [1:0]    res_id;
`ifdef TNN_STATS_EN
  logic [N*CW-1:0] stat_pos;
  logic [N*CW-1:0] stat_tot;
  logic            stat_clr;
`endif

  always #5 clk = ~clk;

  tnn_clf_scheduler #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_feat  (req_feat),
    .clf_feat  (clf_feat),
    .clf_class (clf_class),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_class (res_class),
`ifdef TNN_STATS_EN
    .stat_pos  (stat_pos),
    .stat_tot  (stat_tot),
    .stat_clr  (stat_clr),
`endif
    .res_id    (res_id)
  );

  // Stand-in core: class 1 when the feature sum reaches 5.
  function automatic logic core(input logic [VW-1:0] f);
    int s;
    s = 0;
    for (int k = 0; k < 5; k++) s += int'(f[k*2 +: 2]);
    return s >= 5;
  endfunction

  assign clf_class = core(clf_feat);

  typedef struct {
    int            id;
    logic [VW-1:0] feat;
    logic          cls;
    int            stage;
  } item_t;

  item_t         q[$];
  int            gq[$];
  int            ptr;
  logic [VW-1:0] lastf;
  bit            mvalid;
  int total, bad;

  bit e_acc, e_pop, e_mv, e_rst;
  int e_idx;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check();
    bit s2o, s1o, gok;
    logic [N-1:0] er;
    s2o = q.size() > 0 && q[0].stage == 2;
    s1o = q.size() > 0 && q[q.size()-1].stage == 1;
    e_mv = s1o && (!s2o || res_ready);
    gok = rst_n && en && (!s1o || e_mv);
    e_idx = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (e_idx < 0 && req_valid[j]) e_idx = j;
    end
    e_acc = gok && e_idx >= 0;
    e_pop = s2o && res_ready;
    e_rst = !rst_n;
    er = '0;
    if (e_acc) er[e_idx] = 1'b1;
    if (mvalid) begin
      cmp("req_ready", 32'(req_ready), 32'(er));
      cmp("res_valid", 32'(res_valid), 32'(s2o));
      cmp("clf_feat", 32'(clf_feat), 32'(lastf));
      if (s2o) begin
        cmp("res_class", 32'(res_class), 32'(q[0].cls));
        cmp("res_id", 32'(res_id), 32'(q[0].id));
      end
    end
  endtask

  task automatic update();
    item_t it;
    if (e_rst) begin
      q.delete();
      ptr = 0;
      lastf = '0;
      mvalid = 1'b1;
      return;
    end
    if (!mvalid) return;
    if (e_pop) void'(q.pop_front());
    if (e_mv) q[q.size()-1].stage = 2;
    if (e_acc) begin
      it.id    = e_idx;
      it.feat  = req_feat[e_idx*VW +: VW];
      it.cls   = core(it.feat);
      it.stage = 1;
      q.push_back(it);
      gq.push_back(e_idx);
      lastf = it.feat;
      ptr = (e_idx + 1) % N;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check();
    @(posedge clk);
    update();
    #1;
  endtask

  function automatic logic [N*VW-1:0] rnd_feat();
    return {$urandom, $urandom};
  endfunction

  int gs;

  initial begin
    total = 0; bad = 0; ptr = 0; lastf = '0; mvalid = 1'b0;
    rst_n = 1'b0; en = 1'b1; req_valid = '0; res_ready = 1'b1;
    req_feat = '0;
`ifdef TNN_STATS_EN
    stat_clr = 1'b0;
`endif
    // Reset and idle
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    cmp("idle_feat", 32'(clf_feat), 32'h0);
    cmp("idle_valid", 32'(res_valid), 32'h0);
    cmp("idle_ready", 32'(req_ready), 32'h0);

    // Latency through both stages
    req_feat = rnd_feat();
    req_feat[2*VW +: VW] = 10'h155;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    cmp("lat_feat", 32'(clf_feat), 32'h155);
    cmp("lat_v1", 32'(res_valid), 32'h0);
    tick();
    cmp("lat_valid", 32'(res_valid), 32'h1);
    cmp("lat_class", 32'(res_class), 32'h1);
    cmp("lat_id", 32'(res_id), 32'h2);
    tick();

    // Fairness under full load
    gq.delete();
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      req_feat = rnd_feat();
      tick();
    end
    cmp("fair_cnt", 32'(gq.size()), 32'd12);
    cmp("fair_first", 32'(gq[0]), 32'd3);
    for (int i = 1; i < 12 && i < gq.size(); i++)
      cmp("fair_order", 32'(gq[i]), 32'((3 + i) % 4));

    // Backpressure with both stages full
    res_ready = 1'b0;
    gs = gq.size();
    for (int c = 0; c < 5; c++) begin
      req_feat = rnd_feat();
      tick();
    end
    cmp("stall_grants", 32'(gq.size() - gs), 32'd0);
    res_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      req_feat = rnd_feat();
      tick();
    end

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      en = ($urandom % 4) != 0;
      res_ready = ($urandom % 3) != 0;
      req_feat = rnd_feat();
      tick();
    end

    // Reset with both stages full
    en = 1'b1;
    req_valid = '1;
    res_ready = 1'b0;
    repeat (3) tick();
    cmp("pre_rst_valid", 32'(res_valid), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cmp("rst_valid", 32'(res_valid), 32'h0);
    req_valid = 4'b1010;
    res_ready = 1'b1;
    gs = gq.size();
    tick();
    cmp("rst_grant_n", 32'(gq.size() - gs), 32'd1);
    if (gq.size() > gs)
      cmp("rst_grant_id", 32'(gq[gq.size()-1]), 32'd1);
    req_valid = '0;
    repeat (3) tick();

`ifdef TNN_STATS_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    cmp("st_clr0", 32'(stat_tot[1*CW +: CW]), 32'd0);
    req_valid = 4'b0010;
    req_feat = '1;
    repeat (300) tick();
    req_valid = '0;
    repeat (4) tick();
    cmp("st_pos_sat", 32'(stat_pos[1*CW +: CW]), 32'd255);
    cmp("st_tot_sat", 32'(stat_tot[1*CW +: CW]), 32'd255);
    cmp("st_oth", 32'(stat_tot[0*CW +: CW]), 32'd0);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    cmp("st_pos_clr", 32'(stat_pos[1*CW +: CW]), 32'd0);
    cmp("st_tot_clr", 32'(stat_tot[1*CW +: CW]), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
